// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: walks two latched operands LSB-first through an
// external 1-bit full adder and assembles the sum and final carry.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_a_s;
    logic             fa_b_s;
    logic             fa_cin_s;

    // Sequencer state, operand copies, running carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            c_r     <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        c_r     <= cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r] <= fa_sum;
                    c_r          <= fa_cout;
                    // Last bit: capture overflow carry and leave RUN.
                    if (idx_r == IDX_LAST) begin
                        cout_r  <= fa_cout;
                        idx_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_ONE;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    idx_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Full-adder operand lines: live only in RUN, sourced from held registers.
    always_comb begin
        fa_a_s   = 1'b0;
        fa_b_s   = 1'b0;
        fa_cin_s = 1'b0;
        if (state_r == ST_RUN) begin
            fa_a_s   = a_r[idx_r];
            fa_b_s   = b_r[idx_r];
            fa_cin_s = c_r;
        end else begin
            fa_a_s   = 1'b0;
            fa_b_s   = 1'b0;
            fa_cin_s = 1'b0;
        end
    end

    assign fa_a   = fa_a_s;
    assign fa_b   = fa_b_s;
    assign fa_cin = fa_cin_s;
    assign sum    = sum_r;
    assign cout   = cout_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8) with a behavioural full adder on the fa_* lines.
module tb_serial_add_seq;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       fa_a;
    logic       fa_b;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_cout;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    serial_add_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .sum     (sum),
        .cout    (cout),
        .busy    (busy),
        .done    (done)
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One addition; start rises for edges E0..E(hold-1); ena drops for
    // stall_len edges starting at E(stall_at). Samples on falling edges.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tcin, input logic [7:0] exp_sum, input logic exp_cout,
                         input int hold, input int stall_at, input int stall_len,
                         input bit scramble, input bit skip_wait,
                         output int busy_n, output int done_n, output int first_busy,
                         output logic [7:0] fa_a_bits, output logic [7:0] fa_b_bits,
                         output logic [7:0] fa_c_bits, output int stall_bad);
        int   nrec;
        int   fin;
        logic sa, sb, sc;
        nrec = 0; fin = -1; sa = 1'b0; sb = 1'b0; sc = 1'b0;
        busy_n = 0; done_n = 0; first_busy = 0; stall_bad = 0;
        fa_a_bits = 8'h00; fa_b_bits = 8'h00; fa_c_bits = 8'h00;
        if (!skip_wait) @(negedge clk);
        a = ta; b = tb_v; cin = tcin; start = 1'b1; ena = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) first_busy = int'(busy);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
                check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
                check({tag, "_fa_idle"}, 32'({fa_a, fa_b, fa_cin}), 32'd0);
            end
            if (k == stall_at) begin
                sa = fa_a; sb = fa_b; sc = fa_cin;
            end
            if (stall_len > 0 && k > stall_at && k <= stall_at + stall_len) begin
                if ({fa_a, fa_b, fa_cin} !== {sa, sb, sc} || busy !== 1'b1) stall_bad++;
            end
            if (k >= hold) start = 1'b0;
            ena = !(stall_len > 0 && k >= stall_at && k < stall_at + stall_len);
            if (busy && ena && nrec < 8) begin
                fa_a_bits[nrec] = fa_a;
                fa_b_bits[nrec] = fa_b;
                fa_c_bits[nrec] = fa_cin;
                nrec++;
            end
            if (scramble) begin
                a = 8'($urandom());
                b = 8'($urandom());
                cin = 1'($urandom());
            end
            if (done && fin < 0) fin = k + 3;
            if (k == fin) break;
        end
        start = 1'b0;
        ena = 1'b1;
    endtask

    int         bn, dn, fbz, sbad, nb, nd;
    logic [7:0] fab, fbb, fcb;

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_sum", 32'(sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);

        // Release reset with start already high: first edge must accept.
        rst_n = 1'b1;
        do_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1, 0, 0, 1'b0, 1'b1,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t1_first_busy", 32'(fbz), 32'd1);
        check("t1_busy_cycles", 32'(bn), 32'd8);
        check("t1_done_pulses", 32'(dn), 32'd1);
        check("t1_fa_a", 32'(fab), 32'h5A);
        check("t1_fa_b", 32'(fbb), 32'h3C);
        check("t1_fa_cin", 32'(fcb), 32'hF0);
        check("t1_hold_sum", 32'(sum), 32'h96);

        do_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1, 0, 0, 1'b0, 1'b0,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t2_busy_cycles", 32'(bn), 32'd8);
        check("t2_done_pulses", 32'(dn), 32'd1);
        check("t2_fa_cin", 32'(fcb), 32'hFE);

        do_op("t3", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 10, 0, 0, 1'b0, 1'b0,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t3_busy_cycles", 32'(bn), 32'd8);
        check("t3_done_pulses", 32'(dn), 32'd1);
        check("t3_fa_cin", 32'(fcb), 32'hFF);

        do_op("t4", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1, 4, 3, 1'b0, 1'b0,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t4_busy_cycles", 32'(bn), 32'd11);
        check("t4_done_pulses", 32'(dn), 32'd1);
        check("t4_stall_hold", 32'(sbad), 32'd0);
        check("t4_fa_a", 32'(fab), 32'h12);
        check("t4_fa_cin", 32'(fcb), 32'h60);

        // Reset pulse during the 4th RUN cycle.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("t5_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_sum", 32'(sum), 32'd0);
        check("t5_rst_cout", 32'(cout), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0; nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        check("t5_abandon_busy", 32'(nb), 32'd0);
        check("t5_abandon_done", 32'(nd), 32'd0);
        do_op("t5", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1, 0, 0, 1'b0, 1'b0,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t5_busy_cycles", 32'(bn), 32'd8);
        check("t5_done_pulses", 32'(dn), 32'd1);

        do_op("t6", 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1, 0, 0, 1'b1, 1'b0,
              bn, dn, fbz, fab, fbb, fcb, sbad);
        check("t6_busy_cycles", 32'(bn), 32'd8);
        check("t6_done_pulses", 32'(dn), 32'd1);
        check("t6_fa_a", 32'(fab), 32'h0F);
        check("t6_fa_b", 32'(fbb), 32'hF0);
        @(negedge clk);
        check("t6_hold_sum", 32'(sum), 32'hFF);
        check("t6_hold_cout", 32'(cout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
